mult_result_deser: RTL and testbench
====================================

MULT_RESULT_DESER -- requirements
Module: MULT_result_deser

Interface
REQ-001 Parameter N, default 1024, meaning bit width of the serial operand a.
REQ-002 Parameter M, default N, meaning bit width of the parallel operand X.
REQ-003 Parameter LAT, default 1, meaning cycles between start acceptance and the first product bit on s_bit (LAT >= 0).
REQ-004 Port clk, input, 1 bit, single clock; all state updates on rising edge.
REQ-005 Port rst, input, 1 bit, synchronous active-high reset.
REQ-006 Port start, input, 1 bit, one-cycle pulse aligned with the first serial operand bit fed to the multiplier.
REQ-007 Port s_bit, input, 1 bit, serial product bit from MULT_full_seq (aX), LSB first.
REQ-008 Port p_data, output, N+M bits, assembled parallel product.
REQ-009 Port p_valid, output, 1 bit, p_data holds a complete product.
REQ-010 Port p_ready, input, 1 bit, consumer accepts p_data when p_valid && p_ready.
REQ-011 Port busy, output, 1 bit, high whenever state != IDLE.

Function
REQ-012 The block SHALL implement the states IDLE, SKIP, COLLECT and HOLD.
REQ-013 IDLE: on start=1 go to SKIP if LAT>0, else COLLECT; otherwise remain in IDLE.
REQ-014 SKIP: wait exactly LAT cycles without sampling s_bit, then go to COLLECT.
REQ-015 COLLECT: sample s_bit on each of exactly N+M edges; shift right with s_bit inserted at bit N+M-1, so the first sampled bit ends at bit 0.
REQ-016 After the (N+M)th sample, go to HOLD; p_valid SHALL first be high LAT+N+M cycles after the edge that accepted start.
REQ-017 HOLD: p_valid=1; p_data SHALL be stable; on p_valid && p_ready return to IDLE (p_valid low the next cycle).
REQ-018 start SHALL be ignored in SKIP, COLLECT and HOLD, including a start that coincides with the p_ready handshake.
REQ-019 The cycle counter width SHALL be $clog2(N+M+1); the count SHALL never wrap within one transaction.
REQ-020 p_data SHALL be meaningful only while p_valid=1; its content during COLLECT is unspecified to the consumer.

Reset
REQ-021 rst=1 at a clock edge SHALL force state IDLE, clear the counter, p_data=0, p_valid=0 and busy=0, whatever the current state.
REQ-022 Reset SHALL take priority over start and over p_ready.
REQ-023 Reset mid-COLLECT SHALL discard the partial product; no p_valid pulse follows.

Structure
REQ-024 The state enum and the shared N/M defaults SHALL live in the shared MAC header/package used by MULT_full_seq.
REQ-025 One sub-module, ser2par_shift, SHALL hold the N+M-bit shift register with shift-enable and clear inputs; the FSM and counter SHALL stay in the top module.

Verification
REQ-026 N=M=4, LAT=1: start, skip 1 cycle, then drive bits of 150 (A=15, X=10) LSB first -> p_valid rises 9 cycles after start; p_data=8'h96.
REQ-027 Same run with p_ready low 5 cycles and a start pulse during HOLD -> p_data held at 8'h96, p_valid steady, start ignored; one handshake on p_ready=1, then IDLE.
REQ-028 rst pulsed at the 3rd COLLECT sample -> next cycle p_valid=0, busy=0, p_data=0; a fresh transaction then yields the correct result.
REQ-029 LAT=0, N=M=4: s_bit driven from the cycle after start with the pattern for 3*5=15 -> p_data=8'h0F after 8 cycles.
REQ-030 N=M=1024, LAT=1, coupled to MULT_full_seq with A=all ones, X={512{2'b10}} -> p_data == A*X, error 0.
REQ-031 Back-to-back: start in the cycle after the handshake -> accepted; two consecutive products are both correct.

Source files
------------

// File: rtl/mult_result_deser_pkg.sv
// Shared MAC package: default operand widths and deserializer FSM state encodings.
package mult_result_deser_pkg;

  localparam int DEFAULT_N = 1024;
  localparam int DEFAULT_M = DEFAULT_N;

  // Plain constants instead of an enum so older netlist tools see fixed encodings.
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SKIP    = 2'd1;
  localparam logic [1:0] ST_COLLECT = 2'd2;
  localparam logic [1:0] ST_HOLD    = 2'd3;

endpackage

// File: rtl/mult_result_deser_ser2par_shift.sv
// Serial-to-parallel shift register: shifts right, inserting the new bit at the MSB,
// so the earliest bit ends up at bit 0 after W shifts.
module ser2par_shift #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         shift_en,
  input  logic         s_bit,
  output logic [W-1:0] data
);

  always_ff @(posedge clk) begin
    if (clear) begin
      data <= '0;
    end else if (shift_en) begin
      data <= {s_bit, data[W-1:1]};
    end
  end

endmodule

// File: rtl/mult_result_deser.sv
// Collects the LSB-first serial product of the sequential multiplier into an
// N+M-bit word and offers it with a valid/ready handshake.
module mult_result_deser
  import mult_result_deser_pkg::*;
#(
  parameter int N   = DEFAULT_N,
  parameter int M   = N,
  parameter int LAT = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           s_bit,
  output logic [N+M-1:0] p_data,
  output logic           p_valid,
  input  logic           p_ready,
  output logic           busy
);

  localparam int W   = N + M;
  localparam int CW  = $clog2(W + 1);
  localparam int SKW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam int SKIP_LAST = (LAT > 0) ? LAT - 1 : 0;

  localparam logic [CW-1:0]  CNT_END  = CW'(W - 1);
  localparam logic [SKW-1:0] SKIP_END = SKW'(SKIP_LAST);

  logic [1:0]     state;
  logic [CW-1:0]  cnt;
  logic [SKW-1:0] skip_cnt;
  logic           shift_en;

  assign shift_en = (state == ST_COLLECT);
  assign p_valid  = (state == ST_HOLD);
  assign busy     = (state != ST_IDLE);

  // Counter only reaches W in HOLD, so CW bits never wrap inside a transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      skip_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            cnt      <= '0;
            skip_cnt <= '0;
            state    <= (LAT > 0) ? ST_SKIP : ST_COLLECT;
          end
        end
        ST_SKIP: begin
          if (skip_cnt == SKIP_END) begin
            state <= ST_COLLECT;
          end else begin
            skip_cnt <= skip_cnt + 1'b1;
          end
        end
        ST_COLLECT: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_END) begin
            state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (p_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  ser2par_shift #(
    .W(W)
  ) u_shift (
    .clk      (clk),
    .clear    (rst),
    .shift_en (shift_en),
    .s_bit    (s_bit),
    .data     (p_data)
  );

endmodule

// File: tb/tb_mult_result_deser.sv
// Scoreboard bench for mult_result_deser with N=M=4: one LAT=1 instance for the
// handshake/reset scenarios and one LAT=0 instance for the zero-latency path.
module tb_mult_result_deser;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       s_bit = 1'b0;
  logic       p_ready = 1'b0;
  logic [7:0] p_data;
  logic       p_valid;
  logic       busy;

  logic       start0 = 1'b0;
  logic       s_bit0 = 1'b0;
  logic       p_ready0 = 1'b0;
  logic [7:0] p_data0;
  logic       p_valid0;
  logic       busy0;

  int assertCount = 0;
  int failCount = 0;
  logic [7:0] expQ[$];

  always #5 clk = ~clk;

  mult_result_deser #(.N(4), .M(4), .LAT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .s_bit(s_bit),
    .p_data(p_data), .p_valid(p_valid), .p_ready(p_ready), .busy(busy)
  );

  mult_result_deser #(.N(4), .M(4), .LAT(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .s_bit(s_bit0),
    .p_data(p_data0), .p_valid(p_valid0), .p_ready(p_ready0), .busy(busy0)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full LAT=1 transaction; inputs change 1 time unit after each rising edge.
  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] x, input int readyDelay,
                               input bit startInHold, input bit startAtHandshake);
    logic [7:0] prod;
    prod = 8'(a) * 8'(x);
    expQ.push_back(prod);
    start = 1'b1;
    step();
    start = 1'b0;
    checkOutput("busy_after_start", 32'(busy), 32'd1);
    s_bit = 1'b1;
    step();
    for (int i = 0; i < 8; i++) begin
      s_bit = prod[i];
      if (i == 7) checkOutput("valid_not_early", 32'(p_valid), 32'd0);
      step();
    end
    s_bit = 1'b0;
    checkOutput("valid_rise", 32'(p_valid), 32'd1);
    for (int k = 0; k < readyDelay; k++) begin
      start = startInHold && (k == 1);
      step();
      start = 1'b0;
      checkOutput("hold_valid", 32'(p_valid), 32'd1);
      checkOutput("hold_data", 32'(p_data), 32'(expQ[0]));
    end
    p_ready = 1'b1;
    start = startAtHandshake;
    if (expQ.size() > 0) checkOutput("handshake_data", 32'(p_data), 32'(expQ.pop_front()));
    step();
    p_ready = 1'b0;
    start = 1'b0;
    checkOutput("post_hs_valid", 32'(p_valid), 32'd0);
    checkOutput("post_hs_busy", 32'(busy), 32'd0);
  endtask

  task automatic applyMidCollectReset();
    logic seen;
    seen = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    s_bit = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      s_bit = 1'b1;
      if (i == 2) rst = 1'b1;
      step();
    end
    rst = 1'b0;
    s_bit = 1'b0;
    checkOutput("rst_mid_valid", 32'(p_valid), 32'd0);
    checkOutput("rst_mid_busy", 32'(busy), 32'd0);
    checkOutput("rst_mid_data", 32'(p_data), 32'd0);
    for (int i = 0; i < 12; i++) begin
      step();
      seen = seen | p_valid;
    end
    checkOutput("no_valid_after_rst", 32'(seen), 32'd0);
  endtask

  task automatic applyZeroLatency(input logic [3:0] a, input logic [3:0] x);
    logic [7:0] prod;
    prod = 8'(a) * 8'(x);
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      s_bit0 = prod[i];
      if (i == 7) checkOutput("lat0_valid_not_early", 32'(p_valid0), 32'd0);
      step();
    end
    s_bit0 = 1'b0;
    checkOutput("lat0_valid", 32'(p_valid0), 32'd1);
    checkOutput("lat0_data", 32'(p_data0), 32'(prod));
    p_ready0 = 1'b1;
    step();
    p_ready0 = 1'b0;
    checkOutput("lat0_post_hs_busy", 32'(busy0), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checkOutput("reset_valid", 32'(p_valid), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_data", 32'(p_data), 32'd0);

    applyStimulus(4'd15, 4'd10, 5, 1'b1, 1'b0);
    applyStimulus(4'd7, 4'd9, 0, 1'b0, 1'b1);
    applyStimulus(4'd12, 4'd13, 0, 1'b0, 1'b0);
    applyStimulus(4'd15, 4'd15, 2, 1'b0, 1'b0);
    applyStimulus(4'd0, 4'd9, 1, 1'b0, 1'b0);
    applyMidCollectReset();
    applyStimulus(4'd15, 4'd10, 0, 1'b0, 1'b0);

    applyZeroLatency(4'd3, 4'd5);
    applyZeroLatency(4'd11, 4'd6);

    checkOutput("queue_empty", 32'(expQ.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
